// File: rtl/tour_cmd.sv
// tour_cmd
// ---------------------------------------------------------------------------
// Replays a solved knight's tour as motion commands to the command processor.
// Each knight move becomes two commands: a vertical leg (opcode 4'h4) followed
// by a horizontal leg with fanfare (opcode 4'h5). While no tour is replaying,
// UART-wrapper commands pass straight through to the command processor.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_tour        : one-cycle pulse that begins a replay
//   move [7:0]        : one-hot move for the current mv_indx (comb. from solver)
//   mv_indx [4:0]     : index into the solver move list
//   cmd_UART [15:0]   : command from the UART wrapper
//   cmd_rdy_UART      : UART command valid
//   clr_cmd_rdy_UART  : acknowledge back to the UART wrapper
//   cmd [15:0]        : command to the command processor
//   cmd_rdy           : cmd valid
//   clr_cmd_rdy       : command processor accepted cmd
//   send_resp         : command processor finished executing a command
//   resp [7:0]        : response byte to the UART wrapper
//   tour_active       : replay in progress
// ---------------------------------------------------------------------------
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_active
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;
    localparam logic [7:0] HDG_NORTH  = 8'h00;
    localparam logic [7:0] HDG_WEST   = 8'h3F;
    localparam logic [7:0] HDG_SOUTH  = 8'h7F;
    localparam logic [7:0] HDG_EAST   = 8'hBF;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_BUSY  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VERT   = 3'd1,
        ST_WAIT_V = 3'd2,
        ST_HORZ   = 3'd3,
        ST_WAIT_H = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  mv_indx_r;
    logic [4:0]  mv_indx_nxt_s;
    logic        move_vld_s;
    logic        last_move_s;
    logic [15:0] vert_cmd_s;
    logic [15:0] horz_cmd_s;

    // Position of the lowest set bit; a non-one-hot move decodes as that bit.
    function automatic logic [2:0] lowest_bit(input logic [7:0] mv);
        logic [2:0] idx;
        idx = 3'd0;
        for (int b = 7; b >= 0; b--) begin
            if (mv[b]) begin
                idx = 3'(b);
            end
        end
        return idx;
    endfunction

    // Vertical leg of a knight move: N1, N2, S1 or S2.
    function automatic logic [15:0] decode_vert(input logic [7:0] mv);
        logic [15:0] c;
        case (lowest_bit(mv))
            3'd0, 3'd3: c = {OP_MOVE, HDG_NORTH, 4'd1};
            3'd1, 3'd2: c = {OP_MOVE, HDG_NORTH, 4'd2};
            3'd4, 3'd7: c = {OP_MOVE, HDG_SOUTH, 4'd1};
            3'd5, 3'd6: c = {OP_MOVE, HDG_SOUTH, 4'd2};
            default:    c = {OP_MOVE, HDG_NORTH, 4'd0};
        endcase
        return c;
    endfunction

    // Horizontal leg of a knight move (with fanfare): E1, E2, W1 or W2.
    function automatic logic [15:0] decode_horz(input logic [7:0] mv);
        logic [15:0] c;
        case (lowest_bit(mv))
            3'd0, 3'd7: c = {OP_FANFARE, HDG_EAST, 4'd2};
            3'd1, 3'd6: c = {OP_FANFARE, HDG_EAST, 4'd1};
            3'd2, 3'd5: c = {OP_FANFARE, HDG_WEST, 4'd1};
            3'd3, 3'd4: c = {OP_FANFARE, HDG_WEST, 4'd2};
            default:    c = {OP_FANFARE, HDG_EAST, 4'd0};
        endcase
        return c;
    endfunction

    // Move decode; move == 0 marks the end of the solved list.
    always_comb begin
        move_vld_s  = (move != 8'h00);
        last_move_s = (mv_indx_r == LAST_IDX);
        vert_cmd_s  = decode_vert(move);
        horz_cmd_s  = decode_horz(move);
    end

    // State and move-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mv_indx_r <= 5'd0;
        end else begin
            state_r   <= state_nxt_s;
            mv_indx_r <= mv_indx_nxt_s;
        end
    end

    // Next-state logic. send_resp only matters in the WAIT states, so a
    // response coinciding with clr_cmd_rdy in VERT/HORZ is dropped.
    always_comb begin
        state_nxt_s   = state_r;
        mv_indx_nxt_s = mv_indx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_tour) begin
                    state_nxt_s   = ST_VERT;
                    mv_indx_nxt_s = 5'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_VERT: begin
                if (!move_vld_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (clr_cmd_rdy) begin
                    state_nxt_s = ST_WAIT_V;
                end else begin
                    state_nxt_s = ST_VERT;
                end
            end
            ST_WAIT_V: begin
                if (send_resp) begin
                    state_nxt_s = ST_HORZ;
                end else begin
                    state_nxt_s = ST_WAIT_V;
                end
            end
            ST_HORZ: begin
                if (!move_vld_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (clr_cmd_rdy) begin
                    state_nxt_s = ST_WAIT_H;
                end else begin
                    state_nxt_s = ST_HORZ;
                end
            end
            ST_WAIT_H: begin
                if (send_resp && last_move_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (send_resp) begin
                    state_nxt_s   = ST_VERT;
                    mv_indx_nxt_s = mv_indx_r + 5'd1;
                end else begin
                    state_nxt_s = ST_WAIT_H;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                mv_indx_nxt_s = 5'd0;
            end
        endcase
    end

    // Output mux: pass-through when idle, tour commands while replaying.
    always_comb begin
        tour_active      = (state_r != ST_IDLE);
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (tour_active) begin
            // UART command stays pending until the tour finishes.
            clr_cmd_rdy_UART = 1'b0;
            if ((state_r == ST_HORZ) || (state_r == ST_WAIT_H)) begin
                cmd = horz_cmd_s;
            end else begin
                cmd = vert_cmd_s;
            end
            // A zero move aborts without ever raising cmd_rdy.
            cmd_rdy = ((state_r == ST_VERT) || (state_r == ST_HORZ)) && move_vld_s;
            if ((state_r == ST_WAIT_H) && last_move_s) begin
                resp = RESP_DONE;
            end else begin
                resp = RESP_BUSY;
            end
        end else begin
            cmd_rdy = cmd_rdy_UART;
        end
    end

    assign mv_indx = mv_indx_r;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: pass-through, all eight move decodes, a full
// 24-move tour, UART holdoff, zero-move abort and reset mid-tour.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_active;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rdy   = 0;
    bit prev_rdy = 1'b0;

    logic [7:0]  moves [0:23];
    logic [15:0] exp_v [0:7];
    logic [15:0] exp_h [0:7];

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tour_active(tour_active)
    );

    always #5 clk = ~clk;

    // Solver model: move follows mv_indx with zero latency.
    assign move = (mv_indx < 5'd24) ? moves[mv_indx] : 8'h00;

    // Count tour command assertions (rising edges of cmd_rdy while active).
    always @(negedge clk) begin
        if (tour_active && cmd_rdy && !prev_rdy) n_rdy++;
        prev_rdy = tour_active && cmd_rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Play move i starting in VERT; optionally stop once WAIT_H is reached.
    task automatic do_move(input int i, input bit stop_in_wait_h);
        int k;
        k = i % 8;
        check($sformatf("v_cmd[%0d]", i), 32'(cmd), 32'(exp_v[k]));
        check($sformatf("v_rdy[%0d]", i), 32'(cmd_rdy), 32'd1);
        check($sformatf("v_idx[%0d]", i), 32'(mv_indx), 32'(i));
        check($sformatf("v_resp[%0d]", i), 32'(resp), 32'h5A);
        // Acknowledge with a coincident send_resp, which must be ignored.
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        #1;
        check($sformatf("holdoff_v[%0d]", i), 32'(clr_cmd_rdy_UART), 32'd0);
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        if (i == 3) start_tour = 1'b1;
        #1;
        check($sformatf("wv_rdy[%0d]", i), 32'(cmd_rdy), 32'd0);
        tick();
        start_tour = 1'b0;
        #1;
        // Still waiting: early send_resp and mid-tour start_tour had no effect.
        check($sformatf("wv_hold[%0d]", i), 32'(cmd_rdy), 32'd0);
        check($sformatf("wv_idx[%0d]", i), 32'(mv_indx), 32'(i));
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        #1;
        check($sformatf("h_cmd[%0d]", i), 32'(cmd), 32'(exp_h[k]));
        check($sformatf("h_rdy[%0d]", i), 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        check($sformatf("holdoff_h[%0d]", i), 32'(clr_cmd_rdy_UART), 32'd0);
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        check($sformatf("wh_rdy[%0d]", i), 32'(cmd_rdy), 32'd0);
        check($sformatf("wh_resp[%0d]", i), 32'(resp), (i == 23) ? 32'hA5 : 32'h5A);
        if (!stop_in_wait_h) begin
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            #1;
        end
    endtask

    task automatic start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        #1;
    endtask

    initial begin
        exp_v[0] = 16'h4001; exp_h[0] = 16'h5BF2;
        exp_v[1] = 16'h4002; exp_h[1] = 16'h5BF1;
        exp_v[2] = 16'h4002; exp_h[2] = 16'h53F1;
        exp_v[3] = 16'h4001; exp_h[3] = 16'h53F2;
        exp_v[4] = 16'h47F1; exp_h[4] = 16'h53F2;
        exp_v[5] = 16'h47F2; exp_h[5] = 16'h53F1;
        exp_v[6] = 16'h47F2; exp_h[6] = 16'h5BF1;
        exp_v[7] = 16'h47F1; exp_h[7] = 16'h5BF2;
        for (int i = 0; i < 24; i++) moves[i] = 8'h01 << (i % 8);
        moves[9] = 8'h06;  // non-one-hot: lowest bit (bit1) wins

        rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        #12;
        check("rst_active", 32'(tour_active), 32'd0);
        check("rst_idx", 32'(mv_indx), 32'd0);
        check("rst_resp", 32'(resp), 32'hA5);
        check("rst_cmd", 32'(cmd), 32'h1234);
        check("rst_rdy", 32'(cmd_rdy), 32'd1);
        rst_n = 1'b1;
        tick();

        // Pass-through.
        cmd_UART = 16'h4003; cmd_rdy_UART = 1'b1;
        #1;
        check("pt_cmd", 32'(cmd), 32'h4003);
        check("pt_rdy", 32'(cmd_rdy), 32'd1);
        check("pt_clr0", 32'(clr_cmd_rdy_UART), 32'd0);
        check("pt_resp", 32'(resp), 32'hA5);
        clr_cmd_rdy = 1'b1;
        #1;
        check("pt_clr1", 32'(clr_cmd_rdy_UART), 32'd1);
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        check("pt_clr2", 32'(clr_cmd_rdy_UART), 32'd0);

        // Full tour with a UART command pending throughout.
        n_rdy = 0;
        start();
        check("start_active", 32'(tour_active), 32'd1);
        for (int i = 0; i < 24; i++) do_move(i, 1'b0);
        check("end_active", 32'(tour_active), 32'd0);
        check("end_resp", 32'(resp), 32'hA5);
        check("end_cmd", 32'(cmd), 32'h4003);
        check("end_rdy", 32'(cmd_rdy), 32'd1);
        check("end_idx", 32'(mv_indx), 32'd23);
        check("rdy_count", 32'(n_rdy), 32'd48);

        // Abort on move == 0 at index 5.
        moves[5] = 8'h00;
        n_rdy = 0;
        start();
        for (int i = 0; i < 5; i++) do_move(i, 1'b0);
        check("abort_idx", 32'(mv_indx), 32'd5);
        check("abort_rdy", 32'(cmd_rdy), 32'd0);
        check("abort_clr", 32'(clr_cmd_rdy_UART), 32'd0);
        tick();
        check("abort_idle", 32'(tour_active), 32'd0);
        check("abort_count", 32'(n_rdy), 32'd10);
        moves[5] = 8'h20;

        // Reset in WAIT_H of move 7, then restart.
        start();
        for (int i = 0; i < 7; i++) do_move(i, 1'b0);
        do_move(7, 1'b1);
        check("pre_rst_idx", 32'(mv_indx), 32'd7);
        rst_n = 1'b0;
        #1;
        check("mrst_active", 32'(tour_active), 32'd0);
        check("mrst_idx", 32'(mv_indx), 32'd0);
        check("mrst_resp", 32'(resp), 32'hA5);
        check("mrst_cmd", 32'(cmd), 32'h4003);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(tour_active), 32'd0);
        start();
        check("restart_idx", 32'(mv_indx), 32'd0);
        check("restart_cmd", 32'(cmd), 32'h4001);
        check("restart_rdy", 32'(cmd_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
